mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Parametrised next-generation multicycle MIPS control unit. It sits between the instruction register fields and the multicycle datapath.
- Adds a memory ready handshake so memory latency can vary, plus BNE, ADDI and J support.
- Adds an illegal-instruction trap and a retired-instruction counter.
- Moore FSM drives all datapath enables; only alu_control in EXECUTE and the branch qualifiers depend on IR fields.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1
ALUCTL_W, 3, alu_control width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_write  out  1  write strobe, qualified by mem_req
i_or_d  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  unconditional PC write
branch  out  1  BEQ qualifier
branch_ne  out  1  BNE qualifier
pc_en  out  1  pc_write | (branch & zero) | (branch_ne & ~zero)
pc_src  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
alu_control  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = memory data, 0 = ALUOut
reg_write  out  1  register file write
illegal  out  1  sticky trap flag
state  out  4  current state (debug)
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset: on the clk edge with reset=1, state=FETCH(0), instr_count=0 and illegal=0. Reset overrides all other events. Reset mid-instruction abandons the instruction; mem_req/mem_write follow the state, so they drop once the state is FETCH.
- Default for every output not listed in a state: 0.
- States and encodings:
  - FETCH 0: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write = pc_write = mem_ready (single-cycle pulse). Go to DECODE when mem_ready, else hold.
  - DECODE 1: alu_src_a=0, alu_src_b=11, add. Next state by opcode:
    - LW 100011 or SW 101011: MEMADR
    - R-type 000000 with legal funct: EXECUTE
    - BEQ 000100 or BNE 000101: BRANCH
    - ADDI 001000: ADDIEXEC
    - J 000010: JUMP
    - anything else, including R-type with an unsupported funct: ILLEGAL
  - MEMADR 2: alu_src_a=1, alu_src_b=10, add. Next state MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD 3: mem_req=1, i_or_d=1. Go to MEMWB when mem_ready, else hold.
  - MEMWB 4: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH; retires.
  - MEMWRITE 5: mem_req=1, mem_write=1, i_or_d=1. Go to FETCH when mem_ready (retires), else hold.
  - EXECUTE 6: alu_src_a=1, alu_src_b=00. alu_control decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Next state ALUWB.
  - ALUWB 7: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH; retires.
  - BRANCH 8: alu_src_a=1, alu_src_b=00, sub, pc_src=01. branch = (opcode==BEQ), branch_ne = (opcode==BNE). Next state FETCH; retires whether taken or not.
  - ADDIEXEC 9: alu_src_a=1, alu_src_b=10, add. Next state ADDIWB.
  - ADDIWB 10: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH; retires.
  - JUMP 11: pc_src=10, pc_write=1. Next state FETCH; retires.
  - ILLEGAL 12: all strobes 0. illegal is set on entry and stays set; the FSM holds here until reset.
  - Unused encodings 13-15: next state ILLEGAL.
- instr_count increments by 1 on each retiring transition and wraps from all-ones to 0.
- With MEM_HANDSHAKE=0, every instruction has a fixed latency: LW 5 cycles; SW, R-type and ADDI 4; BEQ, BNE and J 3.
- opcode and funct are sampled from the IR, which is stable from DECODE onward.

Decomposition:
- Package mc_pkg: state encoding constants, opcode and funct constants, ALU control codes, alu_src_b and pc_src encodings.
- Sub-module mc_alu_decoder: combinational funct -> {alu_control, funct_valid}. The FSM uses it in DECODE for the legality check and in EXECUTE to drive alu_control.

Test Plan:
1. Reset, then LW with mem_ready=1 throughout -> states 0,1,2,3,4,0. reg_write=1 only in state 4; instr_count=1 after 5 cycles.
2. mem_ready held 0 for 3 cycles in FETCH, then 1 -> state stays 0 for 4 cycles. ir_write and pc_write pulse once, in the 4th cycle.
3. Branch-qualifier matrix:
   - BNE, zero=0 -> pc_en=1 in BRANCH
   - BNE, zero=1 -> pc_en=0
   - BEQ, zero=1 -> pc_en=1
   - instr_count increments in all cases.
4. R-type funct 100010 -> alu_control=110 in EXECUTE, then ALUWB with reg_write=1 and reg_dst=1. ADDI -> alu_src_b=10 in state 9, then reg_dst=0 in state 10.
5. Opcode 111111 (also R-type funct 000111) -> DECODE, then ILLEGAL(12). illegal=1 holds for 10+ cycles and instr_count is unchanged; reset clears it.
6. Reset and wrap:
   - reset asserted in MEMWRITE with mem_ready=0 -> next cycle state=0, mem_write=0, instr_count=0.
   - CNT_W=4 with 16 J instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, IR field
// codes, ALU control codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Where DECODE goes for a given opcode; unsupported encodings trap.
    function automatic state_t decode_next(input logic [5:0] opcode, input logic funct_valid);
        state_t nxt;
        nxt = ILLEGAL;
        case (opcode)
            OP_LW, OP_SW:   nxt = MEMADR;
            OP_RTYPE:       nxt = funct_valid ? EXECUTE : ILLEGAL;
            OP_BEQ, OP_BNE: nxt = BRANCH;
            OP_ADDI:        nxt = ADDIEXEC;
            OP_J:           nxt = JUMP;
            default:        nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: ALU operation plus a legality flag used by DECODE.
module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [5:0]          funct,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                funct_valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        alu_control = ALUCTL_W'(ALU_ADD);
        funct_valid = 1'b1;
        case (funct)
            F_ADD:   alu_control = ALUCTL_W'(ALU_ADD);
            F_SUB:   alu_control = ALUCTL_W'(ALU_SUB);
            F_AND:   alu_control = ALUCTL_W'(ALU_AND);
            F_OR:    alu_control = ALUCTL_W'(ALU_OR);
            F_SLT:   alu_control = ALUCTL_W'(ALU_SLT);
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM with memory handshake, illegal-instruction
// trap and a retired-instruction counter.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int ALUCTL_W      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic                pc_en,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instr_count
);

    state_t                state_q;
    state_t                decode_target;
    logic                  mem_rdy;
    logic                  funct_valid;
    logic [ALUCTL_W-1:0]   funct_alu;

    // Without the handshake every memory access completes in a single cycle.
    assign mem_rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign decode_target = decode_next(opcode, funct_valid);
    assign state         = state_q;

    mc_alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
        .funct       (funct),
        .alu_control (funct_alu),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state and counters use non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state_q     <= FETCH;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            case (state_q)
                FETCH:    if (mem_rdy) state_q <= DECODE;
                DECODE: begin
                    state_q <= decode_target;
                    if (decode_target == ILLEGAL) illegal <= 1'b1;
                end
                MEMADR:   state_q <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_rdy) state_q <= MEMWB;
                MEMWRITE: if (mem_rdy) begin
                    state_q     <= FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                EXECUTE:  state_q <= ALUWB;
                ADDIEXEC: state_q <= ADDIWB;
                MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
                    state_q     <= FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                ILLEGAL:  state_q <= ILLEGAL;
                default: begin
                    state_q <= ILLEGAL;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        alu_control = '0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALUCTL_W'(ALU_ADD);
                ir_write    = mem_rdy;
                pc_write    = mem_rdy;
            end
            DECODE: begin
                alu_src_b   = SRCB_IMM_SH;
                alu_control = ALUCTL_W'(ALU_ADD);
            end
            MEMADR, ADDIEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALUCTL_W'(ALU_ADD);
            end
            MEMREAD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALUCTL_W'(ALU_SUB);
                pc_src      = PCSRC_ALUOUT;
                branch      = (opcode == OP_BEQ);
                branch_ne   = (opcode == OP_BNE);
            end
            ADDIWB:  reg_write = 1'b1;
            JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control trace, a monitor compares it.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWRITE = 5, S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8,
                   S_ADDIEXEC = 9, S_ADDIWB = 10, S_JUMP = 11, S_ILLEGAL = 12;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
                           T_J = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t            c;
        logic [CNT_W-1:0] cnt;
        int               id;
    } exp_t;

    typedef enum {C_LW, C_SW, C_R, C_BR, C_ADDI, C_J, C_ILL} iclass_t;

    logic             clk = 1'b0;
    logic             reset, zero, mem_ready;
    logic [5:0]       opcode, funct;
    logic             mem_req, mem_write, i_or_d, ir_write, pc_write, branch, branch_ne, pc_en;
    logic [1:0]       pc_src, alu_src_b;
    logic             alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
    logic [2:0]       alu_control;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    mc_control_fsm #(.CNT_W(CNT_W), .MEM_HANDSHAKE(1'b1), .ALUCTL_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    int               n_compared   = 0;
    int               n_mismatched = 0;
    int               instr_id     = 0;
    logic [CNT_W-1:0] exp_count;
    exp_t             mon_e;
    ctrl_t            mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            T_LW:          return C_LW;
            T_SW:          return C_SW;
            T_R:           return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? C_R : C_ILL;
            T_BEQ, T_BNE:  return C_BR;
            T_ADDI:        return C_ADDI;
            T_J:           return C_J;
            default:       return C_ILL;
        endcase
    endfunction

    // Expected control vector for one cycle, straight from the per-state output table.
    function automatic ctrl_t model_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input logic mr);
        ctrl_t c;
        c = '0;
        c.st = 4'(st);
        case (st)
            S_FETCH:    begin c.mem_req = 1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
                              c.ir_write = mr; c.pc_write = mr; end
            S_DECODE:   begin c.alu_src_b = 2'b11; c.alu_control = 3'b010; end
            S_MEMADR,
            S_ADDIEXEC: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 3'b010; end
            S_MEMREAD:  begin c.mem_req = 1; c.i_or_d = 1; end
            S_MEMWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEMWRITE: begin c.mem_req = 1; c.mem_write = 1; c.i_or_d = 1; end
            S_EXECUTE:  begin c.alu_src_a = 1; c.alu_control = ref_alu(fn); end
            S_ALUWB:    begin c.reg_write = 1; c.reg_dst = 1; end
            S_BRANCH:   begin c.alu_src_a = 1; c.alu_control = 3'b110; c.pc_src = 2'b01;
                              c.branch = (op == T_BEQ); c.branch_ne = (op == T_BNE); end
            S_ADDIWB:   c.reg_write = 1;
            S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1; end
            S_ILLEGAL:  c.illegal = 1;
            default: ;
        endcase
        c.pc_en = c.pc_write | (c.branch & z) | (c.branch_ne & ~z);
        return c;
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = {state, mem_req, mem_write, i_or_d, ir_write, pc_write, branch, branch_ne,
                       pc_en, pc_src, alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
                       reg_write, illegal};
            check($sformatf("ctrl[instr %0d state %0d]", mon_e.id, mon_e.c.st), 32'(mon_act), 32'(mon_e.c));
            check($sformatf("instr_count[instr %0d]", mon_e.id), 32'(instr_count), 32'(mon_e.cnt));
        end
    end

    task automatic drive_cycle(input int st, input bit mr, input bit z, input bit rst);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        reset     = rst;
        e.c   = model_ctrl(st, opcode, funct, z, mr);
        e.cnt = exp_count;
        e.id  = instr_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_count = '0;
    endtask

    // Expands one instruction into its state path; cut>0 truncates it there with reset asserted.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int sf, input int sm, input int cut);
        int      path[$];
        bit      mrs[$];
        iclass_t k;
        int      n;
        bit      cutting;
        k = classify(op, fn);
        opcode = op;
        funct  = fn;
        repeat (sf) begin path.push_back(S_FETCH); mrs.push_back(1'b0); end
        path.push_back(S_FETCH);  mrs.push_back(1'b1);
        path.push_back(S_DECODE); mrs.push_back(1'($urandom));
        case (k)
            C_LW: begin
                path.push_back(S_MEMADR); mrs.push_back(1'($urandom));
                repeat (sm) begin path.push_back(S_MEMREAD); mrs.push_back(1'b0); end
                path.push_back(S_MEMREAD); mrs.push_back(1'b1);
                path.push_back(S_MEMWB);   mrs.push_back(1'($urandom));
            end
            C_SW: begin
                path.push_back(S_MEMADR); mrs.push_back(1'($urandom));
                repeat (sm) begin path.push_back(S_MEMWRITE); mrs.push_back(1'b0); end
                path.push_back(S_MEMWRITE); mrs.push_back(1'b1);
            end
            C_R: begin
                path.push_back(S_EXECUTE); mrs.push_back(1'($urandom));
                path.push_back(S_ALUWB);   mrs.push_back(1'($urandom));
            end
            C_BR:   begin path.push_back(S_BRANCH); mrs.push_back(1'($urandom)); end
            C_ADDI: begin
                path.push_back(S_ADDIEXEC); mrs.push_back(1'($urandom));
                path.push_back(S_ADDIWB);   mrs.push_back(1'($urandom));
            end
            C_J:    begin path.push_back(S_JUMP); mrs.push_back(1'($urandom)); end
            default: repeat (sm + 1) begin path.push_back(S_ILLEGAL); mrs.push_back(1'($urandom)); end
        endcase
        cutting = (cut > 0) && (cut <= path.size());
        n = cutting ? cut : path.size();
        for (int i = 0; i < n; i++)
            drive_cycle(path[i], mrs[i], (path[i] == S_BRANCH) ? z : 1'($urandom), cutting && (i == n - 1));
        if (cutting)
            exp_count = '0;
        else if (k != C_ILL)
            exp_count = exp_count + 1'b1;
        instr_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_fn [5];
        logic [5:0] bad_op [4];
        logic [5:0] bad_fn [4];
        legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad_op   = '{6'b111111, 6'b000011, 6'b001111, 6'b100000};
        bad_fn   = '{6'b000111, 6'b000000, 6'b100001, 6'b101011};

        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
        exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(T_LW, 6'b0, 1'b0, 0, 0, 0);           // plain LW path 0,1,2,3,4
        run_instr(T_R, 6'b100000, 1'b0, 3, 0, 0);       // three FETCH stall cycles
        run_instr(T_BNE, 6'b0, 1'b0, 0, 0, 0);
        run_instr(T_BNE, 6'b0, 1'b1, 0, 0, 0);
        run_instr(T_BEQ, 6'b0, 1'b1, 0, 0, 0);
        run_instr(T_BEQ, 6'b0, 1'b0, 0, 0, 0);
        run_instr(T_R, 6'b100010, 1'b0, 0, 0, 0);
        run_instr(T_ADDI, 6'b0, 1'b0, 0, 0, 0);
        run_instr(T_LW, 6'b0, 1'b0, 1, 2, 0);
        run_instr(T_SW, 6'b0, 1'b0, 0, 3, 0);
        run_instr(6'b111111, 6'b0, 1'b0, 0, 11, 0);     // illegal opcode held 12 cycles
        do_reset();
        run_instr(T_R, 6'b000111, 1'b0, 0, 10, 0);      // unsupported funct
        do_reset();
        run_instr(T_J, 6'b0, 1'b0, 0, 0, 0);
        run_instr(T_SW, 6'b0, 1'b0, 0, 2, 4);           // reset lands in MEMWRITE, mem_ready=0
        for (int i = 0; i < 17; i++)
            run_instr(T_J, 6'b0, 1'b0, 0, 0, 0);        // counter wraps through 0

        for (int i = 0; i < 80; i++) begin
            int pick;
            int sf;
            int sm;
            pick = $urandom_range(0, 9);
            sf   = $urandom_range(0, 3);
            sm   = $urandom_range(0, 3);
            case (pick)
                0: run_instr(T_LW, 6'($urandom), 1'b0, sf, sm, 0);
                1: run_instr(T_SW, 6'($urandom), 1'b0, sf, sm, 0);
                2, 3: run_instr(T_R, legal_fn[$urandom_range(0, 4)], 1'b0, sf, sm, 0);
                4: run_instr(T_BEQ, 6'($urandom), 1'($urandom), sf, sm, 0);
                5: run_instr(T_BNE, 6'($urandom), 1'($urandom), sf, sm, 0);
                6: run_instr(T_ADDI, 6'($urandom), 1'b0, sf, sm, 0);
                7: run_instr(T_J, 6'($urandom), 1'b0, sf, sm, 0);
                8: begin run_instr(bad_op[$urandom_range(0, 3)], 6'($urandom), 1'b0, sf, sm, 0); do_reset(); end
                default: begin run_instr(T_R, bad_fn[$urandom_range(0, 3)], 1'b0, sf, sm, 0); do_reset(); end
            endcase
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
